// File: rtl/axi_arbiter_2to1.sv
// Two-master to one-slave AXI4 arbiter. Write and read directions are arbitrated
// independently with round-robin priority and one outstanding transaction each.
module axi_arbiter_2to1 #(
    parameter int ID_WIDTH   = 10,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rstn,
    // master 0
    input  logic [ID_WIDTH-1:0]     s0_axi_awid,     input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic [7:0]              s0_axi_awlen,    input  logic [2:0]              s0_axi_awsize,
    input  logic [1:0]              s0_axi_awburst,  input  logic                    s0_axi_awlock,
    input  logic [3:0]              s0_axi_awcache,  input  logic [2:0]              s0_axi_awprot,
    input  logic [3:0]              s0_axi_awregion, input  logic [3:0]              s0_axi_awqos,
    input  logic [USER_WIDTH-1:0]   s0_axi_awuser,   input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wlast,    input  logic [USER_WIDTH-1:0]   s0_axi_wuser,
    input  logic                    s0_axi_wvalid,   output logic                    s0_axi_wready,
    output logic [ID_WIDTH-1:0]     s0_axi_bid,      output logic [1:0]              s0_axi_bresp,
    output logic [USER_WIDTH-1:0]   s0_axi_buser,    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ID_WIDTH-1:0]     s0_axi_arid,     input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic [7:0]              s0_axi_arlen,    input  logic [2:0]              s0_axi_arsize,
    input  logic [1:0]              s0_axi_arburst,  input  logic                    s0_axi_arlock,
    input  logic [3:0]              s0_axi_arcache,  input  logic [2:0]              s0_axi_arprot,
    input  logic [3:0]              s0_axi_arregion, input  logic [3:0]              s0_axi_arqos,
    input  logic [USER_WIDTH-1:0]   s0_axi_aruser,   input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [ID_WIDTH-1:0]     s0_axi_rid,      output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [1:0]              s0_axi_rresp,    output logic                    s0_axi_rlast,
    output logic [USER_WIDTH-1:0]   s0_axi_ruser,    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready,
    // master 1
    input  logic [ID_WIDTH-1:0]     s1_axi_awid,     input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic [7:0]              s1_axi_awlen,    input  logic [2:0]              s1_axi_awsize,
    input  logic [1:0]              s1_axi_awburst,  input  logic                    s1_axi_awlock,
    input  logic [3:0]              s1_axi_awcache,  input  logic [2:0]              s1_axi_awprot,
    input  logic [3:0]              s1_axi_awregion, input  logic [3:0]              s1_axi_awqos,
    input  logic [USER_WIDTH-1:0]   s1_axi_awuser,   input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                    s1_axi_wlast,    input  logic [USER_WIDTH-1:0]   s1_axi_wuser,
    input  logic                    s1_axi_wvalid,   output logic                    s1_axi_wready,
    output logic [ID_WIDTH-1:0]     s1_axi_bid,      output logic [1:0]              s1_axi_bresp,
    output logic [USER_WIDTH-1:0]   s1_axi_buser,    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    input  logic [ID_WIDTH-1:0]     s1_axi_arid,     input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic [7:0]              s1_axi_arlen,    input  logic [2:0]              s1_axi_arsize,
    input  logic [1:0]              s1_axi_arburst,  input  logic                    s1_axi_arlock,
    input  logic [3:0]              s1_axi_arcache,  input  logic [2:0]              s1_axi_arprot,
    input  logic [3:0]              s1_axi_arregion, input  logic [3:0]              s1_axi_arqos,
    input  logic [USER_WIDTH-1:0]   s1_axi_aruser,   input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [ID_WIDTH-1:0]     s1_axi_rid,      output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic [1:0]              s1_axi_rresp,    output logic                    s1_axi_rlast,
    output logic [USER_WIDTH-1:0]   s1_axi_ruser,    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready,
    // shared downstream slave
    output logic [ID_WIDTH-1:0]     m_axi_awid,      output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,     output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,   output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,   output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awregion,  output logic [3:0]              m_axi_awqos,
    output logic [USER_WIDTH-1:0]   m_axi_awuser,    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,     output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,     output logic [USER_WIDTH-1:0]   m_axi_wuser,
    output logic                    m_axi_wvalid,    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,       input  logic [1:0]              m_axi_bresp,
    input  logic [USER_WIDTH-1:0]   m_axi_buser,     input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ID_WIDTH-1:0]     m_axi_arid,      output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,     output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,   output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,   output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arregion,  output logic [3:0]              m_axi_arqos,
    output logic [USER_WIDTH-1:0]   m_axi_aruser,    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,       input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,     input  logic                    m_axi_rlast,
    input  logic [USER_WIDTH-1:0]   m_axi_ruser,     input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_BUSY}         rstate_t;

    wstate_t wstate, wstate_nxt;
    rstate_t rstate, rstate_nxt;
    logic    wgnt, wgnt_nxt, wlast_gnt, wlast_gnt_nxt, aw_done, aw_done_nxt, w_done, w_done_nxt;
    logic    rgnt, rgnt_nxt, rlast_gnt, rlast_gnt_nxt, ar_done, ar_done_nxt;
    logic    aw_open, w_open, w_resp, ar_open, r_busy;
    logic    aw_hs, w_hs, b_hs, ar_hs, r_hs;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate    <= W_IDLE;
            wgnt      <= 1'b0;
            wlast_gnt <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rstate    <= R_IDLE;
            rgnt      <= 1'b0;
            rlast_gnt <= 1'b1;
            ar_done   <= 1'b0;
        end else begin
            wstate    <= wstate_nxt;
            wgnt      <= wgnt_nxt;
            wlast_gnt <= wlast_gnt_nxt;
            aw_done   <= aw_done_nxt;
            w_done    <= w_done_nxt;
            rstate    <= rstate_nxt;
            rgnt      <= rgnt_nxt;
            rlast_gnt <= rlast_gnt_nxt;
            ar_done   <= ar_done_nxt;
        end
    end

    // Write direction: the flags look at this cycle's handshakes so W_RESP follows the last one directly.
    always_comb begin
        wstate_nxt    = wstate;
        wgnt_nxt      = wgnt;
        wlast_gnt_nxt = wlast_gnt;
        aw_done_nxt   = aw_done;
        w_done_nxt    = w_done;
        case (wstate)
            W_IDLE: begin
                if (s0_axi_awvalid || s1_axi_awvalid) begin
                    wgnt_nxt      = (s0_axi_awvalid && s1_axi_awvalid) ? ~wlast_gnt : s1_axi_awvalid;
                    wlast_gnt_nxt = wgnt_nxt;
                    wstate_nxt    = W_BUSY;
                end
            end
            W_BUSY: begin
                aw_done_nxt = aw_done | aw_hs;
                w_done_nxt  = w_done | (w_hs & m_axi_wlast);
                if (aw_done_nxt && w_done_nxt) begin
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    wstate_nxt  = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) wstate_nxt = W_IDLE;
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_nxt    = rstate;
        rgnt_nxt      = rgnt;
        rlast_gnt_nxt = rlast_gnt;
        ar_done_nxt   = ar_done;
        case (rstate)
            R_IDLE: begin
                if (s0_axi_arvalid || s1_axi_arvalid) begin
                    rgnt_nxt      = (s0_axi_arvalid && s1_axi_arvalid) ? ~rlast_gnt : s1_axi_arvalid;
                    rlast_gnt_nxt = rgnt_nxt;
                    rstate_nxt    = R_BUSY;
                end
            end
            R_BUSY: begin
                ar_done_nxt = ar_done | ar_hs;
                if (r_hs && m_axi_rlast) begin
                    ar_done_nxt = 1'b0;
                    rstate_nxt  = R_IDLE;
                end
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    assign aw_open = (wstate == W_BUSY) && !aw_done;
    assign w_open  = (wstate == W_BUSY) && !w_done;
    assign w_resp  = (wstate == W_RESP);
    assign r_busy  = (rstate == R_BUSY);
    assign ar_open = r_busy && !ar_done;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;
    assign b_hs  = m_axi_bvalid & m_axi_bready;
    assign ar_hs = m_axi_arvalid & m_axi_arready;
    assign r_hs  = m_axi_rvalid & m_axi_rready;

    assign m_axi_awvalid  = aw_open & (wgnt ? s1_axi_awvalid : s0_axi_awvalid);
    assign m_axi_wvalid   = w_open & (wgnt ? s1_axi_wvalid : s0_axi_wvalid);
    assign m_axi_bready   = w_resp & (wgnt ? s1_axi_bready : s0_axi_bready);
    assign m_axi_arvalid  = ar_open & (rgnt ? s1_axi_arvalid : s0_axi_arvalid);
    assign m_axi_rready   = r_busy & (rgnt ? s1_axi_rready : s0_axi_rready);

    assign s0_axi_awready = aw_open & ~wgnt & m_axi_awready;
    assign s1_axi_awready = aw_open & wgnt & m_axi_awready;
    assign s0_axi_wready  = w_open & ~wgnt & m_axi_wready;
    assign s1_axi_wready  = w_open & wgnt & m_axi_wready;
    assign s0_axi_bvalid  = w_resp & ~wgnt & m_axi_bvalid;
    assign s1_axi_bvalid  = w_resp & wgnt & m_axi_bvalid;
    assign s0_axi_arready = ar_open & ~rgnt & m_axi_arready;
    assign s1_axi_arready = ar_open & rgnt & m_axi_arready;
    assign s0_axi_rvalid  = r_busy & ~rgnt & m_axi_rvalid;
    assign s1_axi_rvalid  = r_busy & rgnt & m_axi_rvalid;

    // Request payloads follow the stored grant; response payloads fan out to both masters.
    assign m_axi_awid     = wgnt ? s1_axi_awid     : s0_axi_awid;
    assign m_axi_awaddr   = wgnt ? s1_axi_awaddr   : s0_axi_awaddr;
    assign m_axi_awlen    = wgnt ? s1_axi_awlen    : s0_axi_awlen;
    assign m_axi_awsize   = wgnt ? s1_axi_awsize   : s0_axi_awsize;
    assign m_axi_awburst  = wgnt ? s1_axi_awburst  : s0_axi_awburst;
    assign m_axi_awlock   = wgnt ? s1_axi_awlock   : s0_axi_awlock;
    assign m_axi_awcache  = wgnt ? s1_axi_awcache  : s0_axi_awcache;
    assign m_axi_awprot   = wgnt ? s1_axi_awprot   : s0_axi_awprot;
    assign m_axi_awregion = wgnt ? s1_axi_awregion : s0_axi_awregion;
    assign m_axi_awqos    = wgnt ? s1_axi_awqos    : s0_axi_awqos;
    assign m_axi_awuser   = wgnt ? s1_axi_awuser   : s0_axi_awuser;
    assign m_axi_wdata    = wgnt ? s1_axi_wdata    : s0_axi_wdata;
    assign m_axi_wstrb    = wgnt ? s1_axi_wstrb    : s0_axi_wstrb;
    assign m_axi_wlast    = wgnt ? s1_axi_wlast    : s0_axi_wlast;
    assign m_axi_wuser    = wgnt ? s1_axi_wuser    : s0_axi_wuser;
    assign m_axi_arid     = rgnt ? s1_axi_arid     : s0_axi_arid;
    assign m_axi_araddr   = rgnt ? s1_axi_araddr   : s0_axi_araddr;
    assign m_axi_arlen    = rgnt ? s1_axi_arlen    : s0_axi_arlen;
    assign m_axi_arsize   = rgnt ? s1_axi_arsize   : s0_axi_arsize;
    assign m_axi_arburst  = rgnt ? s1_axi_arburst  : s0_axi_arburst;
    assign m_axi_arlock   = rgnt ? s1_axi_arlock   : s0_axi_arlock;
    assign m_axi_arcache  = rgnt ? s1_axi_arcache  : s0_axi_arcache;
    assign m_axi_arprot   = rgnt ? s1_axi_arprot   : s0_axi_arprot;
    assign m_axi_arregion = rgnt ? s1_axi_arregion : s0_axi_arregion;
    assign m_axi_arqos    = rgnt ? s1_axi_arqos    : s0_axi_arqos;
    assign m_axi_aruser   = rgnt ? s1_axi_aruser   : s0_axi_aruser;

    assign s0_axi_bid   = m_axi_bid;    assign s1_axi_bid   = m_axi_bid;
    assign s0_axi_bresp = m_axi_bresp;  assign s1_axi_bresp = m_axi_bresp;
    assign s0_axi_buser = m_axi_buser;  assign s1_axi_buser = m_axi_buser;
    assign s0_axi_rid   = m_axi_rid;    assign s1_axi_rid   = m_axi_rid;
    assign s0_axi_rdata = m_axi_rdata;  assign s1_axi_rdata = m_axi_rdata;
    assign s0_axi_rresp = m_axi_rresp;  assign s1_axi_rresp = m_axi_rresp;
    assign s0_axi_rlast = m_axi_rlast;  assign s1_axi_rlast = m_axi_rlast;
    assign s0_axi_ruser = m_axi_ruser;  assign s1_axi_ruser = m_axi_ruser;

endmodule

// File: tb/tb_axi_arbiter_2to1.sv
// Directed self-checking bench for axi_arbiter_2to1: a hand-driven downstream slave
// and two hand-driven masters, with expected values written out per scenario.
module tb_axi_arbiter_2to1;
    localparam int IW = 10;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int UW = 6;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // master-side signals (s0_*, s1_*)
    logic [IW-1:0]   s0_axi_awid, s1_axi_awid, s0_axi_arid, s1_axi_arid;
    logic [AW-1:0]   s0_axi_awaddr, s1_axi_awaddr, s0_axi_araddr, s1_axi_araddr;
    logic [7:0]      s0_axi_awlen, s1_axi_awlen, s0_axi_arlen, s1_axi_arlen;
    logic [2:0]      s0_axi_awsize, s1_axi_awsize, s0_axi_arsize, s1_axi_arsize;
    logic [1:0]      s0_axi_awburst, s1_axi_awburst, s0_axi_arburst, s1_axi_arburst;
    logic            s0_axi_awlock, s1_axi_awlock, s0_axi_arlock, s1_axi_arlock;
    logic [3:0]      s0_axi_awcache, s1_axi_awcache, s0_axi_arcache, s1_axi_arcache;
    logic [2:0]      s0_axi_awprot, s1_axi_awprot, s0_axi_arprot, s1_axi_arprot;
    logic [3:0]      s0_axi_awregion, s1_axi_awregion, s0_axi_arregion, s1_axi_arregion;
    logic [3:0]      s0_axi_awqos, s1_axi_awqos, s0_axi_arqos, s1_axi_arqos;
    logic [UW-1:0]   s0_axi_awuser, s1_axi_awuser, s0_axi_aruser, s1_axi_aruser;
    logic            s0_axi_awvalid, s1_axi_awvalid, s0_axi_arvalid, s1_axi_arvalid;
    logic            s0_axi_awready, s1_axi_awready, s0_axi_arready, s1_axi_arready;
    logic [DW-1:0]   s0_axi_wdata, s1_axi_wdata;
    logic [DW/8-1:0] s0_axi_wstrb, s1_axi_wstrb;
    logic            s0_axi_wlast, s1_axi_wlast, s0_axi_wvalid, s1_axi_wvalid;
    logic [UW-1:0]   s0_axi_wuser, s1_axi_wuser;
    logic            s0_axi_wready, s1_axi_wready;
    logic [IW-1:0]   s0_axi_bid, s1_axi_bid, s0_axi_rid, s1_axi_rid;
    logic [1:0]      s0_axi_bresp, s1_axi_bresp, s0_axi_rresp, s1_axi_rresp;
    logic [UW-1:0]   s0_axi_buser, s1_axi_buser, s0_axi_ruser, s1_axi_ruser;
    logic            s0_axi_bvalid, s1_axi_bvalid, s0_axi_bready, s1_axi_bready;
    logic [DW-1:0]   s0_axi_rdata, s1_axi_rdata;
    logic            s0_axi_rlast, s1_axi_rlast, s0_axi_rvalid, s1_axi_rvalid;
    logic            s0_axi_rready, s1_axi_rready;

    // downstream signals (m_*)
    logic [IW-1:0]   m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
    logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
    logic [7:0]      m_axi_awlen, m_axi_arlen;
    logic [2:0]      m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]      m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic            m_axi_awlock, m_axi_arlock;
    logic [3:0]      m_axi_awcache, m_axi_arcache, m_axi_awregion, m_axi_arregion, m_axi_awqos, m_axi_arqos;
    logic [UW-1:0]   m_axi_awuser, m_axi_aruser, m_axi_wuser, m_axi_buser, m_axi_ruser;
    logic            m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic            m_axi_bvalid, m_axi_bready;
    logic            m_axi_rlast, m_axi_rvalid, m_axi_rready;

    int checks = 0;
    int passed = 0;

    axi_arbiter_2to1 #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
        .clk(clk), .rstn(rstn),
        .s0_axi_awid(s0_axi_awid), .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awlen(s0_axi_awlen),
        .s0_axi_awsize(s0_axi_awsize), .s0_axi_awburst(s0_axi_awburst), .s0_axi_awlock(s0_axi_awlock),
        .s0_axi_awcache(s0_axi_awcache), .s0_axi_awprot(s0_axi_awprot), .s0_axi_awregion(s0_axi_awregion),
        .s0_axi_awqos(s0_axi_awqos), .s0_axi_awuser(s0_axi_awuser), .s0_axi_awvalid(s0_axi_awvalid),
        .s0_axi_awready(s0_axi_awready),
        .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_wlast(s0_axi_wlast),
        .s0_axi_wuser(s0_axi_wuser), .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
        .s0_axi_bid(s0_axi_bid), .s0_axi_bresp(s0_axi_bresp), .s0_axi_buser(s0_axi_buser),
        .s0_axi_bvalid(s0_axi_bvalid), .s0_axi_bready(s0_axi_bready),
        .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen),
        .s0_axi_arsize(s0_axi_arsize), .s0_axi_arburst(s0_axi_arburst), .s0_axi_arlock(s0_axi_arlock),
        .s0_axi_arcache(s0_axi_arcache), .s0_axi_arprot(s0_axi_arprot), .s0_axi_arregion(s0_axi_arregion),
        .s0_axi_arqos(s0_axi_arqos), .s0_axi_aruser(s0_axi_aruser), .s0_axi_arvalid(s0_axi_arvalid),
        .s0_axi_arready(s0_axi_arready),
        .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
        .s0_axi_rlast(s0_axi_rlast), .s0_axi_ruser(s0_axi_ruser), .s0_axi_rvalid(s0_axi_rvalid),
        .s0_axi_rready(s0_axi_rready),
        .s1_axi_awid(s1_axi_awid), .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awlen(s1_axi_awlen),
        .s1_axi_awsize(s1_axi_awsize), .s1_axi_awburst(s1_axi_awburst), .s1_axi_awlock(s1_axi_awlock),
        .s1_axi_awcache(s1_axi_awcache), .s1_axi_awprot(s1_axi_awprot), .s1_axi_awregion(s1_axi_awregion),
        .s1_axi_awqos(s1_axi_awqos), .s1_axi_awuser(s1_axi_awuser), .s1_axi_awvalid(s1_axi_awvalid),
        .s1_axi_awready(s1_axi_awready),
        .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb), .s1_axi_wlast(s1_axi_wlast),
        .s1_axi_wuser(s1_axi_wuser), .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
        .s1_axi_bid(s1_axi_bid), .s1_axi_bresp(s1_axi_bresp), .s1_axi_buser(s1_axi_buser),
        .s1_axi_bvalid(s1_axi_bvalid), .s1_axi_bready(s1_axi_bready),
        .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen),
        .s1_axi_arsize(s1_axi_arsize), .s1_axi_arburst(s1_axi_arburst), .s1_axi_arlock(s1_axi_arlock),
        .s1_axi_arcache(s1_axi_arcache), .s1_axi_arprot(s1_axi_arprot), .s1_axi_arregion(s1_axi_arregion),
        .s1_axi_arqos(s1_axi_arqos), .s1_axi_aruser(s1_axi_aruser), .s1_axi_arvalid(s1_axi_arvalid),
        .s1_axi_arready(s1_axi_arready),
        .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
        .s1_axi_rlast(s1_axi_rlast), .s1_axi_ruser(s1_axi_ruser), .s1_axi_rvalid(s1_axi_rvalid),
        .s1_axi_rready(s1_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awregion(m_axi_awregion),
        .m_axi_awqos(m_axi_awqos), .m_axi_awuser(m_axi_awuser), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wuser(m_axi_wuser), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_buser(m_axi_buser),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arregion(m_axi_arregion),
        .m_axi_arqos(m_axi_arqos), .m_axi_aruser(m_axi_aruser), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    // Every valid/ready the arbiter drives, packed for the all-zero checks.
    function automatic logic [14:0] hs_vec();
        return {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
                s0_axi_awready, s0_axi_wready, s0_axi_arready, s0_axi_bvalid, s0_axi_rvalid,
                s1_axi_awready, s1_axi_wready, s1_axi_arready, s1_axi_bvalid, s1_axi_rvalid};
    endfunction

    task automatic clear_inputs;
        {s0_axi_awid, s0_axi_awaddr, s0_axi_awlen, s0_axi_awsize, s0_axi_awburst, s0_axi_awlock} = '0;
        {s0_axi_awcache, s0_axi_awprot, s0_axi_awregion, s0_axi_awqos, s0_axi_awuser, s0_axi_awvalid} = '0;
        {s0_axi_arid, s0_axi_araddr, s0_axi_arlen, s0_axi_arsize, s0_axi_arburst, s0_axi_arlock} = '0;
        {s0_axi_arcache, s0_axi_arprot, s0_axi_arregion, s0_axi_arqos, s0_axi_aruser, s0_axi_arvalid} = '0;
        {s0_axi_wdata, s0_axi_wstrb, s0_axi_wlast, s0_axi_wuser, s0_axi_wvalid, s0_axi_bready, s0_axi_rready} = '0;
        {s1_axi_awid, s1_axi_awaddr, s1_axi_awlen, s1_axi_awsize, s1_axi_awburst, s1_axi_awlock} = '0;
        {s1_axi_awcache, s1_axi_awprot, s1_axi_awregion, s1_axi_awqos, s1_axi_awuser, s1_axi_awvalid} = '0;
        {s1_axi_arid, s1_axi_araddr, s1_axi_arlen, s1_axi_arsize, s1_axi_arburst, s1_axi_arlock} = '0;
        {s1_axi_arcache, s1_axi_arprot, s1_axi_arregion, s1_axi_arqos, s1_axi_aruser, s1_axi_arvalid} = '0;
        {s1_axi_wdata, s1_axi_wstrb, s1_axi_wlast, s1_axi_wuser, s1_axi_wvalid, s1_axi_bready, s1_axi_rready} = '0;
        {m_axi_awready, m_axi_wready, m_axi_arready} = '0;
        {m_axi_bid, m_axi_bresp, m_axi_buser, m_axi_bvalid} = '0;
        {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser, m_axi_rvalid} = '0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rstn = 1'b0;
        // Every handshake input high so a leak through reset would be visible.
        {m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_rvalid} = '1;
        {s0_axi_awvalid, s0_axi_wvalid, s0_axi_arvalid, s0_axi_bready, s0_axi_rready} = '1;
        {s1_axi_awvalid, s1_axi_wvalid, s1_axi_arvalid, s1_axi_bready, s1_axi_rready} = '1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (hs_vec() !== 15'h0) $display("FAIL reset_handshakes: got %h want 0000", hs_vec());
        else passed++;
        @(negedge clk);
        clear_inputs();
        rstn = 1'b1;
        #1;
        checks++;
        if (hs_vec() !== 15'h0) $display("FAIL reset_release_idle: got %h want 0000", hs_vec());
        else passed++;
    endtask

    task automatic test_single_write;
        @(negedge clk);
        s0_axi_awid = 10'h3; s0_axi_awaddr = 64'h1000; s0_axi_awlen = 8'd0; s0_axi_awvalid = 1'b1;
        s0_axi_wdata = 64'hA5; s0_axi_wstrb = '1; s0_axi_wlast = 1'b1; s0_axi_wvalid = 1'b1;
        s0_axi_bready = 1'b1;
        #1;
        checks++;
        if (m_axi_awvalid !== 1'b0) $display("FAIL sw_awvalid_cycle0: got %b want 0", m_axi_awvalid);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b110)
            $display("FAIL sw_valids_cycle1: got %b want 110", {m_axi_awvalid, m_axi_wvalid, m_axi_bready});
        else passed++;
        checks++;
        if (m_axi_awaddr !== 64'h1000 || m_axi_wdata !== 64'hA5)
            $display("FAIL sw_payload: got addr %h data %h want 1000 a5", m_axi_awaddr, m_axi_wdata);
        else passed++;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        #1;
        checks++;
        if ({s0_axi_awready, s0_axi_wready, s1_axi_awready, s1_axi_wready} !== 4'b1100)
            $display("FAIL sw_readies: got %b want 1100",
                     {s0_axi_awready, s0_axi_wready, s1_axi_awready, s1_axi_wready});
        else passed++;
        @(negedge clk);
        s0_axi_awvalid = 1'b0; s0_axi_wvalid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bid = 10'h3; m_axi_bresp = 2'b00;
        #1;
        checks++;
        if ({s0_axi_bvalid, s1_axi_bvalid, m_axi_bready} !== 3'b101 || s0_axi_bid !== 10'h3)
            $display("FAIL sw_b_route: got bv0/bv1/bready %b bid %h want 101 003",
                     {s0_axi_bvalid, s1_axi_bvalid, m_axi_bready}, s0_axi_bid);
        else passed++;
        @(negedge clk);
        m_axi_bvalid = 1'b0;
        #1;
        checks++;
        if ({s0_axi_bvalid, s1_axi_bvalid, m_axi_bready} !== 3'b000)
            $display("FAIL sw_back_idle: got %b want 000", {s0_axi_bvalid, s1_axi_bvalid, m_axi_bready});
        else passed++;
        s0_axi_bready = 1'b0;
    endtask

    task automatic test_sim_reads;
        @(negedge clk);
        s0_axi_arid = 10'h1; s0_axi_araddr = 64'h2000; s0_axi_arlen = 8'd3; s0_axi_arvalid = 1'b1;
        s1_axi_arid = 10'h2; s1_axi_araddr = 64'h3000; s1_axi_arlen = 8'd3; s1_axi_arvalid = 1'b1;
        s0_axi_rready = 1'b1; s1_axi_rready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (m_axi_arvalid !== 1'b1 || m_axi_arid !== 10'h1 || m_axi_araddr !== 64'h2000)
            $display("FAIL sr_first_grant: got v %b id %h addr %h want 1 001 2000", m_axi_arvalid, m_axi_arid, m_axi_araddr);
        else passed++;
        m_axi_arready = 1'b1;
        #1;
        checks++;
        if ({s0_axi_arready, s1_axi_arready} !== 2'b10)
            $display("FAIL sr_arready: got %b want 10", {s0_axi_arready, s1_axi_arready});
        else passed++;
        @(negedge clk);
        s0_axi_arvalid = 1'b0; m_axi_arready = 1'b0;
        #1;
        checks++;
        if (m_axi_arvalid !== 1'b0) $display("FAIL sr_ar_after_hs: got %b want 0", m_axi_arvalid);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            m_axi_rvalid = 1'b1; m_axi_rid = 10'h1; m_axi_rdata = 64'hD0 + 64'(i); m_axi_rlast = (i == 3);
            #1;
            checks++;
            if ({s0_axi_rvalid, s1_axi_rvalid, s0_axi_rlast} !== {2'b10, (i == 3)} || s0_axi_rdata !== 64'hD0 + 64'(i))
                $display("FAIL sr_s0_beat%0d: got v0/v1/last %b data %h want %b %h", i,
                         {s0_axi_rvalid, s1_axi_rvalid, s0_axi_rlast}, s0_axi_rdata, {2'b10, (i == 3)}, 64'hD0 + 64'(i));
            else passed++;
            @(negedge clk);
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        #1;
        checks++;
        if (m_axi_arvalid !== 1'b0) $display("FAIL sr_turn_n1: got %b want 0", m_axi_arvalid);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if (m_axi_arvalid !== 1'b1 || m_axi_arid !== 10'h2 || m_axi_araddr !== 64'h3000)
            $display("FAIL sr_second_grant: got v %b id %h addr %h want 1 002 3000", m_axi_arvalid, m_axi_arid, m_axi_araddr);
        else passed++;
        m_axi_arready = 1'b1;
        @(negedge clk);
        s1_axi_arvalid = 1'b0; m_axi_arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_axi_rvalid = 1'b1; m_axi_rid = 10'h2; m_axi_rdata = 64'hE0 + 64'(i); m_axi_rlast = (i == 3);
            #1;
            checks++;
            if ({s0_axi_rvalid, s1_axi_rvalid} !== 2'b01 || s1_axi_rdata !== 64'hE0 + 64'(i))
                $display("FAIL sr_s1_beat%0d: got v0/v1 %b data %h want 01 %h", i,
                         {s0_axi_rvalid, s1_axi_rvalid}, s1_axi_rdata, 64'hE0 + 64'(i));
            else passed++;
            @(negedge clk);
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s0_axi_rready = 1'b0; s1_axi_rready = 1'b0;
    endtask

    task automatic test_w_first;
        @(negedge clk);
        s1_axi_awid = 10'h7; s1_axi_awaddr = 64'h4000; s1_axi_awlen = 8'd0; s1_axi_awvalid = 1'b1;
        s1_axi_wdata = 64'h5A; s1_axi_wstrb = '1; s1_axi_wlast = 1'b1; s1_axi_wvalid = 1'b1;
        s1_axi_bready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11 || m_axi_awid !== 10'h7 || m_axi_wdata !== 64'h5A)
            $display("FAIL wf_forward: got v %b id %h data %h want 11 007 5a",
                     {m_axi_awvalid, m_axi_wvalid}, m_axi_awid, m_axi_wdata);
        else passed++;
        // Slave takes W first and refuses AW until it has seen WVALID.
        m_axi_wready = 1'b1; m_axi_awready = 1'b0;
        #1;
        checks++;
        if ({s1_axi_wready, s1_axi_awready, s0_axi_wready} !== 3'b100)
            $display("FAIL wf_w_only: got %b want 100", {s1_axi_wready, s1_axi_awready, s0_axi_wready});
        else passed++;
        @(negedge clk);
        s1_axi_wvalid = 1'b0;
        m_axi_awready = 1'b1;
        #1;
        checks++;
        if ({m_axi_awvalid, s1_axi_awready, s1_axi_wready} !== 3'b110)
            $display("FAIL wf_aw_after_w: got %b want 110", {m_axi_awvalid, s1_axi_awready, s1_axi_wready});
        else passed++;
        @(negedge clk);
        s1_axi_awvalid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bid = 10'h7; m_axi_bresp = 2'b10;
        #1;
        checks++;
        if ({s1_axi_bvalid, s0_axi_bvalid, m_axi_bready} !== 3'b101 || s1_axi_bresp !== 2'b10)
            $display("FAIL wf_b_route: got %b resp %b want 101 10", {s1_axi_bvalid, s0_axi_bvalid, m_axi_bready}, s1_axi_bresp);
        else passed++;
        @(negedge clk);
        m_axi_bvalid = 1'b0; s1_axi_bready = 1'b0;
    endtask

    task automatic test_backpressure;
        int beat = 0;
        int recv = 0;
        int cyc = 0;
        logic tog = 1'b0;
        @(negedge clk);
        s1_axi_arid = 10'h9; s1_axi_araddr = 64'h6000; s1_axi_arlen = 8'd7; s1_axi_arvalid = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (m_axi_arvalid !== 1'b1 || m_axi_arlen !== 8'd7 || m_axi_arid !== 10'h9)
            $display("FAIL bp_ar: got v %b len %0d id %h want 1 7 009", m_axi_arvalid, m_axi_arlen, m_axi_arid);
        else passed++;
        m_axi_arready = 1'b1;
        @(negedge clk);
        s1_axi_arvalid = 1'b0; m_axi_arready = 1'b0;
        while (recv < 8 && cyc < 40) begin
            s1_axi_rready = tog;
            m_axi_rvalid = (beat < 8); m_axi_rid = 10'h9;
            m_axi_rdata = 64'h100 + 64'(beat); m_axi_rlast = (beat == 7);
            #1;
            checks++;
            if (m_axi_rready !== tog) $display("FAIL bp_rready_c%0d: got %b want %b", cyc, m_axi_rready, tog);
            else passed++;
            if (s1_axi_rvalid && s1_axi_rready) begin
                checks++;
                if (s1_axi_rdata !== 64'h100 + 64'(recv))
                    $display("FAIL bp_data%0d: got %h want %h", recv, s1_axi_rdata, 64'h100 + 64'(recv));
                else passed++;
                recv++;
            end
            if (m_axi_rvalid && m_axi_rready) beat++;
            tog = ~tog;
            @(negedge clk);
            cyc++;
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        checks++;
        if (recv !== 8) $display("FAIL bp_beat_count: got %0d want 8", recv);
        else passed++;
        s1_axi_rready = 1'b1;
        #1;
        checks++;
        if (m_axi_rready !== 1'b0) $display("FAIL bp_back_idle: got %b want 0", m_axi_rready);
        else passed++;
        s1_axi_rready = 1'b0;
    endtask

    task automatic test_concurrent;
        @(negedge clk);
        s0_axi_awid = 10'h31; s0_axi_awaddr = 64'h7000; s0_axi_awlen = 8'd1; s0_axi_awvalid = 1'b1;
        s0_axi_wdata = 64'hAAAA; s0_axi_wlast = 1'b0; s0_axi_wvalid = 1'b1; s0_axi_bready = 1'b1;
        s1_axi_arid = 10'h32; s1_axi_araddr = 64'h8000; s1_axi_arlen = 8'd1; s1_axi_arvalid = 1'b1;
        s1_axi_rready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({m_axi_awvalid, m_axi_arvalid} !== 2'b11 || m_axi_awid !== 10'h31 || m_axi_arid !== 10'h32)
            $display("FAIL cc_grants: got v %b awid %h arid %h want 11 031 032", {m_axi_awvalid, m_axi_arvalid}, m_axi_awid, m_axi_arid);
        else passed++;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        @(negedge clk);
        s0_axi_awvalid = 1'b0; s1_axi_arvalid = 1'b0; m_axi_awready = 1'b0; m_axi_arready = 1'b0;
        s0_axi_wdata = 64'hBBBB; s0_axi_wlast = 1'b1;
        m_axi_rvalid = 1'b1; m_axi_rid = 10'h32; m_axi_rdata = 64'h77; m_axi_rlast = 1'b0;
        #1;
        checks++;
        if ({s1_axi_rvalid, s0_axi_rvalid, m_axi_wvalid} !== 3'b101 || m_axi_wdata !== 64'hBBBB)
            $display("FAIL cc_overlap: got %b wdata %h want 101 bbbb", {s1_axi_rvalid, s0_axi_rvalid, m_axi_wvalid}, m_axi_wdata);
        else passed++;
        @(negedge clk);
        s0_axi_wvalid = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bid = 10'h31; m_axi_rdata = 64'h78; m_axi_rlast = 1'b1;
        #1;
        checks++;
        if ({s0_axi_bvalid, s1_axi_bvalid, s1_axi_rvalid, s0_axi_rvalid, s1_axi_rlast} !== 5'b10101)
            $display("FAIL cc_no_cross: got %b want 10101",
                     {s0_axi_bvalid, s1_axi_bvalid, s1_axi_rvalid, s0_axi_rvalid, s1_axi_rlast});
        else passed++;
        @(negedge clk);
        m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        #1;
        checks++;
        if ({m_axi_bready, m_axi_rready} !== 2'b00)
            $display("FAIL cc_both_idle: got %b want 00", {m_axi_bready, m_axi_rready});
        else passed++;
        s0_axi_bready = 1'b0; s1_axi_rready = 1'b0;
    endtask

    task automatic test_reset_mid_write;
        @(negedge clk);
        s0_axi_awid = 10'h11; s0_axi_awaddr = 64'h5000; s0_axi_awlen = 8'd3; s0_axi_awvalid = 1'b1;
        s0_axi_wdata = 64'h10; s0_axi_wlast = 1'b0; s0_axi_wvalid = 1'b1;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        s0_axi_awvalid = 1'b0; s0_axi_wdata = 64'h11;
        #1;
        checks++;
        if (s0_axi_wready !== 1'b1) $display("FAIL rm_beat2_active: got %b want 1", s0_axi_wready);
        else passed++;
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (hs_vec() !== 15'h0) $display("FAIL rm_async_clear: got %h want 0000", hs_vec());
        else passed++;
        @(negedge clk);
        s0_axi_wvalid = 1'b0;
        // Last write grant before reset was master 0; the reset pointer still hands the tie to master 0.
        s0_axi_awid = 10'h21; s0_axi_awvalid = 1'b1; s0_axi_wlast = 1'b1; s0_axi_wvalid = 1'b1;
        s1_axi_awid = 10'h22; s1_axi_awvalid = 1'b1; s1_axi_wlast = 1'b1; s1_axi_wvalid = 1'b1;
        rstn = 1'b1;
        #1;
        checks++;
        if (m_axi_awvalid !== 1'b0) $display("FAIL rm_idle_after_release: got %b want 0", m_axi_awvalid);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if (m_axi_awid !== 10'h21 || {s0_axi_awready, s1_axi_awready} !== 2'b10)
            $display("FAIL rm_tie_grant: got id %h ready %b want 021 10", m_axi_awid, {s0_axi_awready, s1_axi_awready});
        else passed++;
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_sim_reads();
        test_w_first();
        test_backpressure();
        test_concurrent();
        test_reset_mid_write();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
        $fatal(1, "timeout");
    end

endmodule
